idli_sqi_ctrl: RTL and testbench
================================

Name: idli_sqi_ctrl

Overview:
Parametrised SQI memory controller driving NUM_MEM quad-SPI memories in lockstep. Each memory holds one nibble slice of every word, generalising the fixed low/high nibble pair to any memory count and word width. Accepts single-word or burst read/write requests from the core and sequences the command, address, dummy and data phases on the shared chip select. Supports write-data stalls by gating the SQI clock.

Parameters:
NUM_MEM, 2, number of attached SQI memories; each carries 4b per beat.
DATA_W, 16, word width. DATA_W must be a multiple of 8*NUM_MEM.
ADDR_W, 16, word address width.
LEN_W, 4, burst length field width; the burst is i_req_len+1 words.
Derived: BEATS = DATA_W/(4*NUM_MEM) beats per word; BPW = BEATS/2 bytes per memory per word.

Ports:
i_clk  in  1  clock
i_rst  in  1  synchronous active-high reset
i_req_vld  in  1  request valid
o_req_rdy  out  1  request ready; high only in IDLE
i_req_wr  in  1  1=write, 0=read
i_req_addr  in  ADDR_W  word address
i_req_len  in  LEN_W  words minus one
i_wr_vld  in  1  write word valid
i_wr_data  in  DATA_W  write word
o_wr_rdy  out  1  write word ready
o_rd_vld  out  1  read word valid pulse; no backpressure
o_rd_data  out  DATA_W  read word
o_busy  out  1  high whenever not IDLE
o_sqi_cs_n  out  1  shared chip select, active low
o_sqi_sck_en  out  1  SQI clock enable; an external gate produces SCK
o_sqi_oe  out  NUM_MEM  per-memory data output enable
o_sqi_data  out  4*NUM_MEM  nibble to memory m at [4m+:4]
i_sqi_data  in  4*NUM_MEM  nibble from memory m at [4m+:4]

Behaviour:
- Reset (synchronous, any state): next cycle is IDLE. cs_n=1, sck_en=0, oe=0, sqi_data=0, rd_vld=0, rd_data=0, wr_rdy=0, busy=0, req_rdy=1. An aborted burst emits no further rd_vld or wr_rdy.
- States: IDLE -> CMD(2) -> ADDR(6) -> [DUMMY(2), reads only] -> DATA(words*BEATS) -> END(1) -> IDLE.
- A request is accepted on cycle T when i_req_vld&&o_req_rdy. The controller latches wr, addr and len; CMD starts at T+1.
- cs_n=0 and busy=1 from T+1 through the last DATA cycle. cs_n=1 in END, giving a guaranteed one-cycle deselect gap.
- sck_en=1 in every CMD/ADDR/DUMMY/DATA cycle except write stalls.
- CMD: byte 0x03 for read, 0x02 for write, MS nibble first, on all memories. oe=all-ones.
- ADDR: byte address = i_req_addr*BPW, zero-extended or truncated to 24b. Driven MS nibble first over 6 cycles, identical on all memories. oe=all-ones.
- DUMMY: oe=0, sqi_data=0.
- DATA beat b of a word, memory m carries word bits [4*(b*NUM_MEM+m)+:4]. Beat 0 goes first.
- Read DATA: oe=0. i_sqi_data is sampled every DATA cycle. After a word's last beat is sampled, o_rd_vld=1 for exactly one cycle (the next cycle) with the assembled word. The last word's rd_vld coincides with END.
- Write DATA: oe=all-ones. o_wr_rdy=1 in every beat-0 cycle and is 0 otherwise.
  - Beat-0 cycle with i_wr_vld=1: the word is accepted, beat 0 is driven combinationally from i_wr_data, and the remaining beats come from a latched copy.
  - Beat-0 cycle with i_wr_vld=0 (stall): sck_en=0; state, beat counter, cs_n and oe are held; sqi_data is don't-care. Stalls may last indefinitely.
- Word and beat counters advance only on sck_en=1 cycles. DATA exits after (len+1)*BEATS enabled beats.
- i_req_* inputs are ignored while busy. A held i_req_vld is accepted in the IDLE cycle after END, so back-to-back transactions have exactly one cs_n-high cycle between them.

Test Plan:
- Defaults; write addr 0x0012, data 0xA5C3, len 0, i_wr_vld high -> sqi_data per enabled cycle: 0x00,0x22 (cmd), 0x00,0x00,0x00,0x00,0x11,0x22 (addr), 0xC3,0xA5. cs_n low T+1..T+10, high T+11; wr_rdy high only at T+9.
- Read addr 0x0012, len 0, memory model returns 0xC3 then 0xA5 after dummy -> oe=0 from T+9, one rd_vld pulse at T+13 with rd_data=0xA5C3. req_rdy=1 again at T+14.
- Burst read addr 0x0100, len 2 -> address nibbles 0,0,0,1,0,0; three rd_vld pulses spaced 2 cycles apart carrying words 0..2.
- Write len 1 with i_wr_vld low for 3 cycles before word 1 -> sck_en=0 for exactly those 3 cycles; cs_n stays low; both words appear correctly on the wires.
- Reset asserted during ADDR of a read -> next cycle cs_n=1, busy=0, req_rdy=1; no rd_vld follows.
- i_req_vld held high for two reads -> second request accepted the cycle after END; exactly one cs_n-high cycle between the transactions.

Source files
------------

// File: rtl/idli_sqi_ctrl.sv
// idli_sqi_ctrl: SQI controller driving NUM_MEM quad-SPI memories in lockstep, one nibble slice each.
module idli_sqi_ctrl #(
  parameter int NUM_MEM = 2,
  parameter int DATA_W  = 16,
  parameter int ADDR_W  = 16,
  parameter int LEN_W   = 4
) (
  input  logic                  i_clk,
  input  logic                  i_rst,
  input  logic                  i_req_vld,
  output logic                  o_req_rdy,
  input  logic                  i_req_wr,
  input  logic [ADDR_W-1:0]     i_req_addr,
  input  logic [LEN_W-1:0]      i_req_len,
  input  logic                  i_wr_vld,
  input  logic [DATA_W-1:0]     i_wr_data,
  output logic                  o_wr_rdy,
  output logic                  o_rd_vld,
  output logic [DATA_W-1:0]     o_rd_data,
  output logic                  o_busy,
  output logic                  o_sqi_cs_n,
  output logic                  o_sqi_sck_en,
  output logic [NUM_MEM-1:0]    o_sqi_oe,
  output logic [4*NUM_MEM-1:0]  o_sqi_data,
  input  logic [4*NUM_MEM-1:0]  i_sqi_data
);
  localparam int SW    = 4*NUM_MEM;
  localparam int BEATS = DATA_W/SW;
  localparam int BPW   = BEATS/2;
  localparam int BW    = $clog2(BEATS);
  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_CMD   = 3'd1;
  localparam logic [2:0] S_ADDR  = 3'd2;
  localparam logic [2:0] S_DUMMY = 3'd3;
  localparam logic [2:0] S_DATA  = 3'd4;
  localparam logic [2:0] S_END   = 3'd5;
  logic [2:0]        state_q, state_d, cnt_q, cnt_d;
  logic [BW-1:0]     beat_q, beat_d;
  logic [LEN_W-1:0]  word_q, word_d, len_q, len_d;
  logic              wr_q, wr_d, rd_vld_q, rd_vld_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [DATA_W-1:0] wbuf_q, wbuf_d, racc_q, racc_d, rd_data_q, rd_data_d, wsrc;
  logic [23:0]       baddr;
  logic [3:0]        cmd_nib, addr_nib;
  logic              active, wr_data, stall, last_beat;
  always_comb begin
    baddr        = 24'(addr_q) * 24'(BPW);
    cmd_nib      = cnt_q[0] ? {3'b001, ~wr_q} : 4'h0;
    addr_nib     = 4'(baddr >> (5'd20 - {cnt_q[2:0], 2'b00}));
    active       = state_q != S_IDLE && state_q != S_END;
    wr_data      = state_q == S_DATA && wr_q;
    stall        = wr_data && beat_q == '0 && !i_wr_vld;
    last_beat    = beat_q == BW'(BEATS-1);
    wsrc         = beat_q == '0 ? i_wr_data : wbuf_q;
    o_req_rdy    = state_q == S_IDLE;
    o_busy       = !o_req_rdy;
    o_sqi_cs_n   = !active;
    o_sqi_sck_en = active && !stall;
    o_wr_rdy     = wr_data && beat_q == '0;
    o_sqi_oe     = (state_q == S_CMD || state_q == S_ADDR || wr_data) ? '1 : '0;
    o_sqi_data   = state_q == S_CMD  ? {NUM_MEM{cmd_nib}} :
                   state_q == S_ADDR ? {NUM_MEM{addr_nib}} :
                   wr_data ? wsrc[beat_q*SW +: SW] : '0;
    o_rd_vld     = rd_vld_q;
    o_rd_data    = rd_data_q;
  end
  always_comb begin
    state_d   = state_q;
    cnt_d     = cnt_q + 3'd1;
    beat_d    = beat_q;
    word_d    = word_q;
    len_d     = len_q;
    wr_d      = wr_q;
    addr_d    = addr_q;
    wbuf_d    = wbuf_q;
    racc_d    = racc_q;
    rd_data_d = rd_data_q;
    rd_vld_d  = 1'b0;
    case (state_q)
      S_IDLE: if (i_req_vld) begin
        state_d = S_CMD;
        cnt_d   = '0;
        wr_d    = i_req_wr;
        addr_d  = i_req_addr;
        len_d   = i_req_len;
      end
      S_CMD: if (cnt_q == 3'd1) begin
        state_d = S_ADDR;
        cnt_d   = '0;
      end
      S_ADDR, S_DUMMY: if (cnt_q == (state_q == S_ADDR ? 3'd5 : 3'd1)) begin
        state_d = (state_q == S_ADDR && !wr_q) ? S_DUMMY : S_DATA;
        cnt_d   = '0;
        beat_d  = '0;
        word_d  = '0;
      end
      S_DATA: if (o_sqi_sck_en) begin
        if (wr_q && beat_q == '0) wbuf_d = i_wr_data;
        if (!wr_q) racc_d[beat_q*SW +: SW] = i_sqi_data;
        beat_d = last_beat ? '0 : beat_q + BW'(1);
        if (last_beat) begin
          word_d    = word_q + LEN_W'(1);
          rd_vld_d  = !wr_q;
          rd_data_d = wr_q ? rd_data_q : racc_d;
          if (word_q == len_q) state_d = S_END;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q   <= S_IDLE;
      cnt_q     <= '0;
      beat_q    <= '0;
      word_q    <= '0;
      len_q     <= '0;
      wr_q      <= 1'b0;
      addr_q    <= '0;
      wbuf_q    <= '0;
      racc_q    <= '0;
      rd_data_q <= '0;
      rd_vld_q  <= 1'b0;
    end else begin
      state_q   <= state_d;
      cnt_q     <= cnt_d;
      beat_q    <= beat_d;
      word_q    <= word_d;
      len_q     <= len_d;
      wr_q      <= wr_d;
      addr_q    <= addr_d;
      wbuf_q    <= wbuf_d;
      racc_q    <= racc_d;
      rd_data_q <= rd_data_d;
      rd_vld_q  <= rd_vld_d;
    end
  end
endmodule

// File: tb/tb_idli_sqi_ctrl.sv
// tb_idli_sqi_ctrl: directed checks of idli_sqi_ctrl with default parameters.
module tb_idli_sqi_ctrl;
  logic        i_clk = 1'b0;
  logic        i_rst = 1'b1;
  logic        i_req_vld = 1'b0, i_req_wr = 1'b0, i_wr_vld = 1'b0;
  logic [15:0] i_req_addr = '0, i_wr_data = '0;
  logic [3:0]  i_req_len = '0;
  logic [7:0]  i_sqi_data = '0;
  logic        o_req_rdy, o_wr_rdy, o_rd_vld, o_busy, o_sqi_cs_n, o_sqi_sck_en;
  logic [15:0] o_rd_data;
  logic [1:0]  o_sqi_oe;
  logic [7:0]  o_sqi_data;
  int tests = 0, fails = 0;

  idli_sqi_ctrl dut (
    .i_clk(i_clk), .i_rst(i_rst), .i_req_vld(i_req_vld), .o_req_rdy(o_req_rdy),
    .i_req_wr(i_req_wr), .i_req_addr(i_req_addr), .i_req_len(i_req_len),
    .i_wr_vld(i_wr_vld), .i_wr_data(i_wr_data), .o_wr_rdy(o_wr_rdy),
    .o_rd_vld(o_rd_vld), .o_rd_data(o_rd_data), .o_busy(o_busy),
    .o_sqi_cs_n(o_sqi_cs_n), .o_sqi_sck_en(o_sqi_sck_en), .o_sqi_oe(o_sqi_oe),
    .o_sqi_data(o_sqi_data), .i_sqi_data(i_sqi_data)
  );

  always #5 i_clk = ~i_clk;

  task automatic step;
    @(posedge i_clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  initial begin
    logic [7:0] wexp [10];
    logic [7:0] rexp [8];
    logic [7:0] bnib [8];
    logic [7:0] bdat [6];
    logic [15:0] bwords [3];
    int pulses, stalls;
    wexp   = '{8'h00, 8'h22, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22, 8'hC3, 8'hA5};
    rexp   = '{8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h00, 8'h11, 8'h22};
    bnib   = '{8'h00, 8'h33, 8'h00, 8'h00, 8'h00, 8'h11, 8'h00, 8'h00};
    bdat   = '{8'h34, 8'h12, 8'h78, 8'h56, 8'hBC, 8'h9A};
    bwords = '{16'h1234, 16'h5678, 16'h9ABC};
    step; step;
    i_rst = 1'b0;
    step;
    chk("rst_cs_n", o_sqi_cs_n, 1);
    chk("rst_sck_en", o_sqi_sck_en, 0);
    chk("rst_oe", o_sqi_oe, 0);
    chk("rst_data", o_sqi_data, 0);
    chk("rst_rd_vld", o_rd_vld, 0);
    chk("rst_rd_data", o_rd_data, 0);
    chk("rst_wr_rdy", o_wr_rdy, 0);
    chk("rst_busy", o_busy, 0);
    chk("rst_req_rdy", o_req_rdy, 1);

    // single write, addr 0x0012, data 0xA5C3
    i_req_vld = 1; i_req_wr = 1; i_req_addr = 16'h0012; i_req_len = 0;
    i_wr_vld = 1; i_wr_data = 16'hA5C3;
    step;
    i_req_vld = 0;
    for (int k = 1; k <= 10; k++) begin
      chk($sformatf("wr_cs_n_%0d", k), o_sqi_cs_n, 0);
      chk($sformatf("wr_sck_%0d", k), o_sqi_sck_en, 1);
      chk($sformatf("wr_oe_%0d", k), o_sqi_oe, 2'b11);
      chk($sformatf("wr_data_%0d", k), o_sqi_data, wexp[k-1]);
      chk($sformatf("wr_rdy_%0d", k), o_wr_rdy, k == 9);
      step;
    end
    chk("wr_end_cs_n", o_sqi_cs_n, 1);
    chk("wr_end_busy", o_busy, 1);
    chk("wr_end_sck", o_sqi_sck_en, 0);
    step;
    chk("wr_idle_req_rdy", o_req_rdy, 1);
    i_wr_vld = 0;

    // single read, addr 0x0012
    i_req_vld = 1; i_req_wr = 0; i_req_addr = 16'h0012; i_req_len = 0;
    step;
    i_req_vld = 0;
    for (int k = 1; k <= 12; k++) begin
      i_sqi_data = k == 11 ? 8'hC3 : k == 12 ? 8'hA5 : 8'h00;
      #1;
      chk($sformatf("rd_cs_n_%0d", k), o_sqi_cs_n, 0);
      chk($sformatf("rd_oe_%0d", k), o_sqi_oe, k <= 8 ? 2'b11 : 2'b00);
      if (k <= 8) chk($sformatf("rd_out_%0d", k), o_sqi_data, rexp[k-1]);
      chk($sformatf("rd_vld_%0d", k), o_rd_vld, 0);
      step;
    end
    i_sqi_data = 0;
    chk("rd_vld_pulse", o_rd_vld, 1);
    chk("rd_word", o_rd_data, 16'hA5C3);
    chk("rd_end_cs_n", o_sqi_cs_n, 1);
    chk("rd_end_req_rdy", o_req_rdy, 0);
    step;
    chk("rd_idle_req_rdy", o_req_rdy, 1);
    chk("rd_vld_drop", o_rd_vld, 0);

    // burst read addr 0x0100, 3 words
    i_req_vld = 1; i_req_wr = 0; i_req_addr = 16'h0100; i_req_len = 2;
    step;
    i_req_vld = 0;
    pulses = 0;
    for (int k = 1; k <= 17; k++) begin
      i_sqi_data = (k >= 11 && k <= 16) ? bdat[k-11] : 8'h00;
      #1;
      if (k <= 8) chk($sformatf("br_out_%0d", k), o_sqi_data, bnib[k-1]);
      chk($sformatf("br_vld_%0d", k), o_rd_vld, k == 13 || k == 15 || k == 17);
      if (o_rd_vld && pulses < 3) begin
        chk($sformatf("br_word_%0d", pulses), o_rd_data, bwords[pulses]);
        pulses++;
      end
      step;
    end
    i_sqi_data = 0;
    chk("br_pulses", pulses, 3);
    chk("br_idle", o_req_rdy, 1);

    // write burst of 2 with a 3-cycle stall before word 1
    i_req_vld = 1; i_req_wr = 1; i_req_addr = 16'h0000; i_req_len = 1;
    i_wr_vld = 1; i_wr_data = 16'h1357;
    step;
    i_req_vld = 0;
    stalls = 0;
    for (int k = 1; k <= 16; k++) begin
      i_wr_vld  = !(k >= 11 && k <= 13);
      i_wr_data = k <= 9 ? 16'h1357 : k == 14 ? 16'h2468 : 16'hFFFF;
      #1;
      chk($sformatf("st_cs_n_%0d", k), o_sqi_cs_n, k == 16);
      chk($sformatf("st_sck_%0d", k), o_sqi_sck_en, k <= 15 && !(k >= 11 && k <= 13));
      if (k >= 9 && k <= 15) chk($sformatf("st_rdy_%0d", k), o_wr_rdy, k == 9 || (k >= 11 && k <= 14));
      if (k == 9)  chk("st_w0b0", o_sqi_data, 8'h57);
      if (k == 10) chk("st_w0b1", o_sqi_data, 8'h13);
      if (k == 14) chk("st_w1b0", o_sqi_data, 8'h68);
      if (k == 15) chk("st_w1b1", o_sqi_data, 8'h24);
      if (!o_sqi_sck_en && !o_sqi_cs_n) stalls++;
      step;
    end
    chk("st_stall_count", stalls, 3);
    i_wr_vld = 0;
    chk("st_idle", o_req_rdy, 1);

    // reset in the ADDR phase of a read
    i_req_vld = 1; i_req_wr = 0; i_req_addr = 16'h0012; i_req_len = 0;
    step;
    i_req_vld = 0;
    step; step; step;
    i_rst = 1;
    step;
    i_rst = 0;
    chk("ab_cs_n", o_sqi_cs_n, 1);
    chk("ab_busy", o_busy, 0);
    chk("ab_req_rdy", o_req_rdy, 1);
    pulses = 0;
    for (int k = 0; k < 14; k++) begin
      if (o_rd_vld) pulses++;
      step;
    end
    chk("ab_no_rd_vld", pulses, 0);

    // held request: two back-to-back reads
    i_req_vld = 1; i_req_wr = 0; i_req_addr = 16'h0000; i_req_len = 0;
    i_sqi_data = 8'h00;
    chk("bb_first_accept", o_req_rdy, 1);
    step;
    for (int k = 1; k <= 12; k++) step;
    chk("bb_end_cs_n", o_sqi_cs_n, 1);
    chk("bb_end_rd_vld", o_rd_vld, 1);
    chk("bb_end_req_rdy", o_req_rdy, 0);
    step;
    chk("bb_second_accept", o_req_rdy, 1);
    chk("bb_gap_cs_n", o_sqi_cs_n, 1);
    step;
    i_req_vld = 0;
    chk("bb_second_cs_n", o_sqi_cs_n, 0);
    chk("bb_second_busy", o_busy, 1);
    chk("bb_second_cmd", o_sqi_data, 8'h00);
    step;
    chk("bb_second_cmd1", o_sqi_data, 8'h33);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
